// File: rtl/load_store_unit.sv
// load_store_unit: issues one data-memory load/store per command and returns the result.
// Latency: start -> REQ next cycle; ack in REQ cycle k -> done pulse at k+1 (min 2 cycles).
// Backpressure: start is ignored while busy; no queueing, the caller must wait for done.
//
// Optional feature: define LSU_ALIGN_CHECK_EN to reject misaligned effective addresses
// (err with no memory strobe). When undefined, the EA is issued unchanged.
//
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   start, opcode, base, disp,     command from execute: EA = base + sext(disp)
//   store_data
//   busy, done, err, load_data     status/result back to the pipeline
//   mem_addr, mem_wdata,           request to data memory; strobes are held for the
//   mem_opcode, mem_read,          whole REQ phase
//   mem_write
//   mem_rdata, mem_ack             response from data memory
module load_store_unit #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [5:0]        opcode,
  input  logic [63:0]       base,
  input  logic [15:0]       disp,
  input  logic [63:0]       store_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [63:0]       load_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic [5:0]        mem_opcode,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [63:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Last REQ cycle index (counter starts at 0 on the first REQ cycle).
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [5:0] OP_LWZ = 6'd32;
  localparam logic [5:0] OP_LBZ = 6'd34;
  localparam logic [5:0] OP_STW = 6'd36;
  localparam logic [5:0] OP_STB = 6'd38;
  localparam logic [5:0] OP_LHZ = 6'd40;
  localparam logic [5:0] OP_LHA = 6'd42;
  localparam logic [5:0] OP_STH = 6'd44;
  localparam logic [5:0] OP_LD  = 6'd58;
  localparam logic [5:0] OP_STD = 6'd62;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [63:0]         wdata_q, wdata_d;
  logic [5:0]          opcode_q, opcode_d;
  logic                is_load_q, is_load_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [63:0]         load_data_q, load_data_d;

  // Decode of the incoming command.
  logic        in_supported;
  logic        in_load;
  logic [1:0]  in_size;      // log2 of access size in bytes
  logic [63:0] ea;
  logic        misaligned;
  logic [63:0] store_masked;
  logic [63:0] load_ext;
  logic        unused_ea_hi;

  always_comb begin
    in_supported = 1'b1;
    in_load      = 1'b0;
    in_size      = 2'd0;
    case (opcode)
      OP_LBZ:  begin in_load = 1'b1; in_size = 2'd0; end
      OP_LHZ:  begin in_load = 1'b1; in_size = 2'd1; end
      OP_LHA:  begin in_load = 1'b1; in_size = 2'd1; end
      OP_LWZ:  begin in_load = 1'b1; in_size = 2'd2; end
      OP_LD:   begin in_load = 1'b1; in_size = 2'd3; end
      OP_STB:  in_size = 2'd0;
      OP_STH:  in_size = 2'd1;
      OP_STW:  in_size = 2'd2;
      OP_STD:  in_size = 2'd3;
      default: in_supported = 1'b0;
    endcase
  end

  // 64-bit add wraps naturally; truncation to ADDR_W happens at the register.
  assign ea = base + {{48{disp[15]}}, disp};
  assign unused_ea_hi = |(ea >> ADDR_W);

`ifdef LSU_ALIGN_CHECK_EN
  always_comb begin
    case (in_size)
      2'd1:    misaligned = ea[0];
      2'd2:    misaligned = |ea[1:0];
      2'd3:    misaligned = |ea[2:0];
      default: misaligned = 1'b0;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    case (in_size)
      2'd0:    store_masked = {56'd0, store_data[7:0]};
      2'd1:    store_masked = {48'd0, store_data[15:0]};
      2'd2:    store_masked = {32'd0, store_data[31:0]};
      default: store_masked = store_data;
    endcase
  end

  // Width/sign extension of returned data, keyed by the registered opcode.
  always_comb begin
    case (opcode_q)
      OP_LBZ:  load_ext = {56'd0, mem_rdata[7:0]};
      OP_LHZ:  load_ext = {48'd0, mem_rdata[15:0]};
      OP_LHA:  load_ext = {{48{mem_rdata[15]}}, mem_rdata[15:0]};
      OP_LWZ:  load_ext = {32'd0, mem_rdata[31:0]};
      OP_LD:   load_ext = mem_rdata;
      default: load_ext = 64'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    opcode_d    = opcode_q;
    is_load_d   = is_load_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    load_data_d = load_data_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load_data_d = 64'd0;
          if (!in_supported || misaligned) begin
            // Rejected without touching memory; report the error directly.
            state_d = ST_RESP;
            err_d   = 1'b1;
          end else begin
            state_d   = ST_REQ;
            addr_d    = ea[ADDR_W-1:0];
            opcode_d  = opcode;
            is_load_d = in_load;
            wdata_d   = in_load ? 64'd0 : store_masked;
            cnt_d     = '0;
            err_d     = 1'b0;
          end
        end
      end

      ST_REQ: begin
        cnt_d = cnt_q + 1'b1;
        // Ack is checked first so an ack on the final cycle is not a timeout.
        if (mem_ack) begin
          state_d     = ST_RESP;
          err_d       = 1'b0;
          load_data_d = is_load_q ? load_ext : 64'd0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = ST_RESP;
          err_d       = 1'b1;
          load_data_d = 64'd0;
        end
      end

      ST_RESP: begin
        state_d     = ST_IDLE;
        err_d       = 1'b0;
        load_data_d = 64'd0;
        cnt_d       = '0;
      end

      default: begin
        state_d     = ST_IDLE;
        err_d       = 1'b0;
        load_data_d = 64'd0;
        cnt_d       = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= 64'd0;
      opcode_q    <= 6'd0;
      is_load_q   <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      load_data_q <= 64'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      opcode_q    <= opcode_d;
      is_load_q   <= is_load_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      load_data_q <= load_data_d;
    end
  end

  assign busy       = (state_q == ST_REQ) || (state_q == ST_RESP);
  assign done       = (state_q == ST_RESP);
  // err/load_data are only meaningful alongside done; gating keeps them clean otherwise.
  assign err        = done & err_q;
  assign load_data  = done ? load_data_q : 64'd0;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_opcode = opcode_q;
  assign mem_read   = (state_q == ST_REQ) &&  is_load_q;
  assign mem_write  = (state_q == ST_REQ) && !is_load_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam int ADDR_W = 32;
  localparam int TMO    = 16;
`ifdef LSU_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [5:0]        opcode;
  logic [63:0]       base;
  logic [15:0]       disp;
  logic [63:0]       store_data;
  logic              busy, done, err;
  logic [63:0]       load_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic [5:0]        mem_opcode;
  logic              mem_read, mem_write;
  logic [63:0]       mem_rdata;
  logic              mem_ack;

  int n_cmp = 0;
  int n_bad = 0;

  load_store_unit #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .base(base), .disp(disp),
    .store_data(store_data), .busy(busy), .done(done), .err(err), .load_data(load_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_opcode(mem_opcode),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes (0 = unsupported) and direction.
  function automatic int unsigned op_bytes(input logic [5:0] op);
    case (op)
      6'd34, 6'd38:        return 1;
      6'd40, 6'd42, 6'd44: return 2;
      6'd32, 6'd36:        return 4;
      6'd58, 6'd62:        return 8;
      default:             return 0;
    endcase
  endfunction

  function automatic bit op_is_load(input logic [5:0] op);
    return (op == 6'd32) || (op == 6'd34) || (op == 6'd40) || (op == 6'd42) || (op == 6'd58);
  endfunction

  function automatic logic [63:0] low_mask(input int unsigned nbytes);
    if (nbytes >= 8) return '1;
    return (64'd1 << (8 * nbytes)) - 64'd1;
  endfunction

  function automatic logic [63:0] model_load(input logic [5:0] op, input logic [63:0] rd);
    logic [63:0] v;
    v = rd & low_mask(op_bytes(op));
    // lha: two's-complement reinterpretation of the 16-bit value
    if (op == 6'd42 && rd[15]) v = v - 64'h10000;
    return v;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // One command from IDLE. ack_at = REQ cycle (1-based) on which mem_ack is given;
  // values outside 1..TMO mean the memory never answers.
  task automatic run_cmd(input logic [5:0] op, input logic [63:0] b, input logic [15:0] d,
                         input logic [63:0] sd, input int ack_at, input logic [63:0] rd,
                         input string name);
    logic [63:0] ea, exp_addr, exp_wdata, exp_ld;
    int unsigned nb;
    bit ld, ok, exp_err, in_req;
    int exp_done;

    nb  = op_bytes(op);
    ld  = op_is_load(op);
    ea  = b + (64'(d) - (d[15] ? 64'h10000 : 64'h0));
    exp_addr  = ea % (64'd1 << ADDR_W);
    exp_wdata = sd & low_mask(nb);
    ok  = (nb != 0) && !(ALIGN && (ea % 64'(nb) != 0));
    if (!ok) begin
      exp_done = 1; exp_err = 1'b1; exp_ld = 64'd0;
    end else if (ack_at >= 1 && ack_at <= TMO) begin
      exp_done = ack_at + 1; exp_err = 1'b0; exp_ld = ld ? model_load(op, rd) : 64'd0;
    end else begin
      exp_done = TMO + 1; exp_err = 1'b1; exp_ld = 64'd0;
    end

    @(negedge clk);
    start = 1'b1; opcode = op; base = b; disp = d; store_data = sd;
    mem_ack = 1'($urandom_range(0, 1));   // ignored in IDLE
    mem_rdata = rnd64();

    for (int c = 1; c <= exp_done + 1; c++) begin
      @(negedge clk);
      in_req = ok && (c < exp_done);
      check({name, ".busy"}, 64'(busy), 64'(c <= exp_done));
      check({name, ".done"}, 64'(done), 64'(c == exp_done));
      check({name, ".rd"}, 64'(mem_read), 64'(in_req && ld));
      check({name, ".wr"}, 64'(mem_write), 64'(in_req && !ld));
      if (in_req) begin
        check({name, ".addr"}, 64'(mem_addr), exp_addr);
        check({name, ".mop"}, 64'(mem_opcode), 64'(op));
        if (!ld) check({name, ".wdata"}, mem_wdata, exp_wdata);
      end
      if (c == exp_done) begin
        check({name, ".err"}, 64'(err), 64'(exp_err));
        check({name, ".ldata"}, load_data, exp_ld);
      end
      // Stimulus for the next edge: extra starts while busy, stray acks outside REQ.
      mem_ack   = in_req ? (c == ack_at) : 1'($urandom_range(0, 1));
      mem_rdata = (c == ack_at) ? rd : rnd64();
      start     = (c <= exp_done) ? 1'($urandom_range(0, 1)) : 1'b0;
      opcode    = 6'($urandom);
      base      = rnd64();
      disp      = 16'($urandom);
      store_data = rnd64();
    end
  endtask

  logic [5:0] sup_ops [9] = '{6'd32, 6'd34, 6'd40, 6'd42, 6'd58, 6'd36, 6'd38, 6'd44, 6'd62};

  initial begin
    logic [5:0] op;
    rst = 1'b1; start = 1'b0; opcode = 6'd0; base = 64'd0; disp = 16'd0;
    store_data = 64'd0; mem_rdata = 64'd0; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.err", 64'(err), 64'd0);
    check("rst.ldata", load_data, 64'd0);
    check("rst.addr", 64'(mem_addr), 64'd0);
    check("rst.strobes", {62'd0, mem_read, mem_write}, 64'd0);
    rst = 1'b0;

    // Directed cases
    run_cmd(6'd38, 64'h10, 16'h0004, 64'h1122334455667788, 1, 64'd0, "stb");
    run_cmd(6'd42, 64'h2000, 16'h0010, 64'd0, 3, 64'h000000000000F00D, "lha");
    run_cmd(6'd58, 64'h100, 16'hFFF8, 64'd0, 5, 64'h0123456789ABCDEF, "ld");
    run_cmd(6'd32, 64'h40, 16'h0000, 64'd0, 0, 64'd0, "lwz_tmo");
    run_cmd(6'd32, 64'h44, 16'h0000, 64'd0, TMO, 64'hDEADBEEFCAFEF00D, "lwz_last");
    run_cmd(6'd31, 64'h0, 16'h0000, 64'd0, 1, 64'd0, "badop");
    run_cmd(6'd40, 64'h0, 16'h0003, 64'd0, 2, 64'h0000000000008001, "lhz_ea3");
    run_cmd(6'd62, 64'hFFFFFFFFFFFFFFF8, 16'h0010, 64'hA5A5A5A5A5A5A5A5, 2, 64'd0, "std_wrap");

    // Reset in the middle of REQ
    @(negedge clk);
    start = 1'b1; opcode = 6'd58; base = 64'h80; disp = 16'h0; mem_ack = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("mid.rd", 64'(mem_read), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid.busy", 64'(busy), 64'd0);
    check("mid.done", 64'(done), 64'd0);
    check("mid.strobes", {62'd0, mem_read, mem_write}, 64'd0);
    check("mid.addr", 64'(mem_addr), 64'd0);
    check("mid.ldata", load_data, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("mid.nodone", 64'(done), 64'd0);

    // Randomized commands
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 4) == 0) op = 6'($urandom);
      else op = sup_ops[$urandom_range(0, 8)];
      run_cmd(op, rnd64(), 16'($urandom), rnd64(), int'($urandom_range(1, TMO + 3)),
              rnd64(), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
